// File: rtl/button_reader_pkg.sv
// -----------------------------------------------------------------------------
// button_reader_pkg
//   Shared definitions for the push-button reader: the per-channel debounce
//   FSM state type, the 1 ms tick divisor derived from the clock frequency,
//   and a helper that sizes counters for a given maximum value.
// -----------------------------------------------------------------------------
package button_reader_pkg;

  // Per-channel debounce states.
  typedef enum logic [1:0] {
    REL        = 2'd0,
    PRESS_WAIT = 2'd1,
    PRESSED    = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  // Number of system clock cycles per 1 ms tick.
  function automatic int tick_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// -----------------------------------------------------------------------------
// button_debounce_ch
//   One push-button channel: 2-flop synchroniser for the raw active-low pin,
//   debounce FSM counting shared 1 ms ticks, registered press/release pulses
//   and debounced level, plus an optional long-press hold counter.
//
//   Optional feature: define BTN_LONGPRESS_EN to build the hold counter and
//   drive long_pulse; otherwise long_pulse is tied to 0.
//
// Ports
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   btn_n         in   raw button pin, asynchronous, active-low
//   tick          in   1-cycle 1 ms timebase pulse
//   btn_level     out  debounced level, 1 = pressed
//   press_pulse   out  1-cycle pulse when a press is accepted
//   release_pulse out  1-cycle pulse when a release is accepted
//   long_pulse    out  1-cycle pulse once a press has been held LONG_MS ticks
// -----------------------------------------------------------------------------
module button_debounce_ch
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic tick,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  // Elaboration-time sanity checks on the timing parameters.
  if (DEBOUNCE_MS < 1) begin : g_bad_debounce
    $error("button_debounce_ch: DEBOUNCE_MS must be at least 1");
  end
  if (LONG_MS <= DEBOUNCE_MS) begin : g_bad_long
    $error("button_debounce_ch: LONG_MS must exceed DEBOUNCE_MS");
  end

  localparam int             DW       = cnt_width(DEBOUNCE_MS);
  // Acceptance happens on the tick that would take dcnt to DEBOUNCE_MS, so
  // the counter itself never needs to hold more than DEBOUNCE_MS-1.
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEBOUNCE_MS - 1);

  logic [1:0]  sync_ff;
  logic        s;
  btn_state_t  state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic        press_nxt, release_nxt;

  // Synchroniser loads "released" on reset so no spurious press follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], btn_n};
    end
  end

  assign s = ~sync_ff[1];

  // Next-state logic. An input change always takes priority over a tick
  // arriving in the same cycle, so bounces restart the count cleanly.
  always_comb begin
    state_nxt   = state;
    dcnt_nxt    = dcnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      REL: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          dcnt_nxt  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = REL;
        end else if (tick) begin
          if (dcnt >= DEB_LAST) begin
            state_nxt = PRESSED;
            press_nxt = 1'b1;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = REL_WAIT;
          dcnt_nxt  = '0;
        end
      end
      REL_WAIT: begin
        if (s) begin
          state_nxt = PRESSED;
        end else if (tick) begin
          if (dcnt >= DEB_LAST) begin
            state_nxt   = REL;
            release_nxt = 1'b1;
          end else begin
            dcnt_nxt = dcnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = REL;
        dcnt_nxt  = '0;
      end
    endcase
  end

  // Level follows the accepted state; a pending release still reads pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= REL;
      dcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      dcnt          <= dcnt_nxt;
      btn_level     <= (state_nxt == PRESSED) || (state_nxt == REL_WAIT);
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int            HW       = cnt_width(LONG_MS);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_MS);

  logic [HW-1:0] hold_cnt;
  logic          long_q;

  // Hold counter restarts on each accepted press and keeps running through
  // release bounces; saturation guarantees a single long pulse per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_nxt) begin
        hold_cnt <= '0;
      end else if ((state == PRESSED || state == REL_WAIT) && tick &&
                   (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
        long_q   <= (hold_cnt == HOLD_MAX - 1'b1);
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// -----------------------------------------------------------------------------
// button_reader
//   Samples the active-low board push buttons, synchronises and debounces each
//   one, and produces clean levels and 1-cycle press/release/long-press pulses.
//   Holds the shared free-running 1 ms tick divider.
//
//   Optional feature: define BTN_LONGPRESS_EN to enable long-press detection;
//   without it long_pulse stays 0.
//
// Ports
//   clk           in   system clock (CLK_HZ)
//   reset         in   synchronous, active-high reset
//   btn_n         in   [NUM_BTN] raw button pins, active-low
//   btn_level     out  [NUM_BTN] debounced level, 1 = pressed
//   press_pulse   out  [NUM_BTN] 1-cycle press-accepted pulse
//   release_pulse out  [NUM_BTN] 1-cycle release-accepted pulse
//   long_pulse    out  [NUM_BTN] 1-cycle long-press pulse
//   tick_1ms      out  1-cycle pulse every CLK_HZ/1000 cycles
// -----------------------------------------------------------------------------
module button_reader
  import button_reader_pkg::*;
#(
  parameter int NUM_BTN     = 2,
  parameter int CLK_HZ      = 48000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic               tick_1ms
);

  localparam int            TICK_DIV = tick_div(CLK_HZ);
  localparam int            TW       = cnt_width(TICK_DIV - 1);
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] div_cnt;

  // Tick is registered: it is high in the cycle the divider has just
  // wrapped back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_1ms <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      tick_1ms <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      tick_1ms <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .btn_n         (btn_n[i]),
      .tick          (tick_1ms),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_reader.sv
// -----------------------------------------------------------------------------
// tb_button_reader
//   Self-checking bench for button_reader with a 10-cycle tick, 4 ms debounce
//   and 20 ms long press. A behavioural model tracks, per button, how many
//   ticks the synchronised input has disagreed with the accepted level and
//   flips the accepted level once that run reaches the debounce length.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_reader;

  localparam int NUM_BTN     = 2;
  localparam int CLK_HZ      = 10000;
  localparam int DEBOUNCE_MS = 4;
  localparam int LONG_MS     = 20;
  localparam int TICK_DIV    = CLK_HZ / 1000;
`ifdef BTN_LONGPRESS_EN
  localparam int EXP_LONG    = 1;
`else
  localparam int EXP_LONG    = 0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NUM_BTN-1:0] btn_n = '0;
  logic [NUM_BTN-1:0] btn_level, press_pulse, release_pulse, long_pulse;
  logic               tick_1ms;

  always #5 clk = ~clk;

  button_reader #(
    .NUM_BTN     (NUM_BTN),
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .LONG_MS     (LONG_MS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_n         (btn_n),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .tick_1ms      (tick_1ms)
  );

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d required %0d at %0t",
                  tag, observed, expected, $time);
  endtask

  // Reference model state, advanced on every rising edge.
  logic [NUM_BTN-1:0] m_hist0, m_hist1, m_level, m_press, m_release, m_long;
  logic [NUM_BTN-1:0] pressed_now;
  logic               m_tick, tick_seen;
  int                 m_cycle;
  int                 m_run [NUM_BTN];
`ifdef BTN_LONGPRESS_EN
  int                 m_hold [NUM_BTN];
`endif

  always @(posedge clk) begin
    if (reset) begin
      m_hist0   = '1;
      m_hist1   = '1;
      m_level   = '0;
      m_press   = '0;
      m_release = '0;
      m_long    = '0;
      m_tick    = 1'b0;
      m_cycle   = 0;
      for (int c = 0; c < NUM_BTN; c++) begin
        m_run[c] = -1;
`ifdef BTN_LONGPRESS_EN
        m_hold[c] = 0;
`endif
      end
    end else begin
      tick_seen   = m_tick;
      pressed_now = ~m_hist1;
      m_hist1     = m_hist0;
      m_hist0     = btn_n;
      m_cycle++;
      m_tick    = (m_cycle % TICK_DIV) == 0;
      m_press   = '0;
      m_release = '0;
      m_long    = '0;
      for (int c = 0; c < NUM_BTN; c++) begin
`ifdef BTN_LONGPRESS_EN
        if (m_level[c] && tick_seen && m_hold[c] < LONG_MS) begin
          m_hold[c]++;
          if (m_hold[c] == LONG_MS) m_long[c] = 1'b1;
        end
`endif
        if (pressed_now[c] != m_level[c]) begin
          if (m_run[c] < 0) m_run[c] = 0;
          else if (tick_seen) m_run[c]++;
          if (m_run[c] >= DEBOUNCE_MS) begin
            m_level[c] = pressed_now[c];
            m_run[c]   = -1;
            if (pressed_now[c]) begin
              m_press[c] = 1'b1;
`ifdef BTN_LONGPRESS_EN
              m_hold[c] = 0;
`endif
            end else begin
              m_release[c] = 1'b1;
            end
          end
        end else begin
          m_run[c] = -1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("model_tick", 32'(tick_1ms), 32'(m_tick));
    checkOutput("model_level", 32'(btn_level), 32'(m_level));
    checkOutput("model_press", 32'(press_pulse), 32'(m_press));
    checkOutput("model_release", 32'(release_pulse), 32'(m_release));
    checkOutput("model_long", 32'(long_pulse), 32'(m_long));
  end

  int cnt_press [NUM_BTN];
  int cnt_release [NUM_BTN];
  int cnt_long [NUM_BTN];

  task automatic clearCounts();
    for (int c = 0; c < NUM_BTN; c++) begin
      cnt_press[c]   = 0;
      cnt_release[c] = 0;
      cnt_long[c]    = 0;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    for (int c = 0; c < NUM_BTN; c++) begin
      cnt_press[c]   += int'(press_pulse[c]);
      cnt_release[c] += int'(release_pulse[c]);
      cnt_long[c]    += int'(long_pulse[c]);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_BTN-1:0] value, input int cycles);
    btn_n = value;
    repeat (cycles) stepCycle();
  endtask

  task automatic applyReset(input logic [NUM_BTN-1:0] value);
    btn_n = value;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  int first_tick;
  int remaining [NUM_BTN];
  logic [NUM_BTN-1:0] rnd_val;

  initial begin
    clearCounts();

    // Reset held with both buttons pressed.
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({btn_level, press_pulse, release_pulse, long_pulse, tick_1ms}), 32'd0);
    reset = 1'b0;
    btn_n = '1;
    first_tick = 0;
    while (first_tick < 50) begin
      stepCycle();
      first_tick++;
      if (tick_1ms) break;
    end
    checkOutput("first_tick_cycle", 32'(first_tick), 32'(TICK_DIV));
    applyStimulus('1, 2 * TICK_DIV - first_tick);
    checkOutput("no_press_after_reset", 32'(cnt_press[0] + cnt_press[1]), 32'd0);

    // Clean press and release on channel 0.
    clearCounts();
    applyStimulus(2'b10, 60);
    checkOutput("clean_press_count", 32'(cnt_press[0]), 32'd1);
    checkOutput("clean_press_level", 32'(btn_level[0]), 32'd1);
    checkOutput("ch1_idle", 32'(cnt_press[1] + cnt_release[1] + cnt_long[1] + int'(btn_level[1])), 32'd0);
    applyStimulus(2'b11, 60);
    checkOutput("clean_release_count", 32'(cnt_release[0]), 32'd1);
    checkOutput("clean_release_level", 32'(btn_level[0]), 32'd0);

    // Bouncing press.
    clearCounts();
    for (int k = 0; k < 9; k++) applyStimulus({1'b1, (k % 2) == 1}, 7);
    checkOutput("bounce_no_press", 32'(cnt_press[0] + cnt_release[0]), 32'd0);
    applyStimulus(2'b10, 60);
    checkOutput("bounce_single_press", 32'(cnt_press[0]), 32'd1);

    // Release with a one-cycle glitch.
    clearCounts();
    applyStimulus(2'b11, 20);
    applyStimulus(2'b10, 1);
    applyStimulus(2'b11, 70);
    checkOutput("glitch_release_count", 32'(cnt_release[0]), 32'd1);
    checkOutput("glitch_no_press", 32'(cnt_press[0]), 32'd0);
    checkOutput("glitch_release_level", 32'(btn_level[0]), 32'd0);

    // Long press held for 30 ticks.
    clearCounts();
    applyStimulus(2'b10, 60);
    applyStimulus(2'b10, 30 * TICK_DIV);
    checkOutput("long_press_count", 32'(cnt_long[0]), 32'(EXP_LONG));
    applyStimulus(2'b11, 80);
    checkOutput("long_press_once", 32'(cnt_long[0]), 32'(EXP_LONG));

    // Reset in the middle of a press debounce.
    applyStimulus(2'b10, 2 * TICK_DIV);
    applyReset(2'b10);
    clearCounts();
    applyStimulus(2'b10, 35);
    checkOutput("reset_mid_no_press", 32'(cnt_press[0]), 32'd0);
    applyStimulus(2'b10, 15);
    checkOutput("reset_mid_fresh_press", 32'(cnt_press[0]), 32'd1);

    // Randomised activity on both channels, checked against the model.
    rnd_val = btn_n;
    for (int c = 0; c < NUM_BTN; c++) remaining[c] = $urandom_range(1, 50);
    for (int n = 0; n < 5000; n++) begin
      if (n == 2500) applyReset(rnd_val);
      for (int c = 0; c < NUM_BTN; c++) begin
        if (remaining[c] == 0) begin
          rnd_val[c]   = ~rnd_val[c];
          remaining[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12)
                                                    : $urandom_range(30, 350);
        end else begin
          remaining[c]--;
        end
      end
      applyStimulus(rnd_val, 1);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
